// File: rtl/monopix2_ro_emulator.sv
// Emulates the MONOPIX2 chip readout: hits are buffered in a FIFO, then on a
// Freeze/Read handshake each word is shifted out MSB first on DATA_OUT.
module monopix2_ro_emulator #(
    parameter int WORD_WIDTH = 27,
    parameter int DEPTH      = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     HIT_WRITE,
    input  logic [WORD_WIDTH-1:0]    HIT_DATA,
    output logic                     HIT_FULL,
    input  logic                     FREEZE,
    input  logic                     READ,
    output logic                     TOKEN,
    output logic                     DATA_OUT,
    output logic [$clog2(DEPTH):0]   HIT_COUNT,
    output logic                     OVERFLOW,
    output logic                     READ_ERROR
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WORD_WIDTH);
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT_C = BW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                  state_q;
    logic [WORD_WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             count_q, count_d;
    logic [AW:0]             frame_cnt_q, frame_cnt_d;
    logic                    freeze_prev_q, read_prev_q;
    logic [WORD_WIDTH-1:0]   shreg_q;
    logic [BW-1:0]           bit_cnt_q;
    logic                    token_q, data_out_q, overflow_q, read_error_q;

    logic full, pop, push, read_rise, read_ok;

    assign full      = (count_q == DEPTH_C);
    assign pop       = (state_q == LOAD);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push      = HIT_WRITE && (!full || pop);
    assign read_rise = READ && !read_prev_q;
    assign read_ok   = read_rise && (state_q == IDLE) && FREEZE && (frame_cnt_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The frame snapshot excludes anything pushed on or after the freeze edge.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!FREEZE)
            frame_cnt_d = '0;
        else if (!freeze_prev_q)
            frame_cnt_d = count_q;
        else if (pop)
            frame_cnt_d = frame_cnt_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= HIT_DATA;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_cnt_q   <= '0;
            freeze_prev_q <= 1'b0;
            read_prev_q   <= 1'b0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            token_q       <= 1'b0;
            data_out_q    <= 1'b0;
            overflow_q    <= 1'b0;
            read_error_q  <= 1'b0;
        end else begin
            count_q       <= count_d;
            frame_cnt_q   <= frame_cnt_d;
            freeze_prev_q <= FREEZE;
            read_prev_q   <= READ;
            token_q       <= FREEZE ? (frame_cnt_d != '0) : (count_d != '0);

            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (HIT_WRITE && full && !pop)
                overflow_q <= 1'b1;
            if (read_rise && !read_ok)
                read_error_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    data_out_q <= 1'b0;
                    if (read_ok)
                        state_q <= LOAD;
                end
                LOAD: begin
                    data_out_q <= 1'b0;
                    shreg_q    <= mem_q[rd_ptr_q];
                    rd_ptr_q   <= rd_ptr_q + 1'b1;
                    bit_cnt_q  <= '0;
                    state_q    <= SHIFT;
                end
                SHIFT: begin
                    data_out_q <= shreg_q[WORD_WIDTH-1];
                    shreg_q    <= {shreg_q[WORD_WIDTH-2:0], 1'b0};
                    bit_cnt_q  <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT_C)
                        state_q <= IDLE;
                end
                default: begin
                    data_out_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign HIT_FULL   = full;
    assign HIT_COUNT  = count_q;
    assign TOKEN      = token_q;
    assign DATA_OUT   = data_out_q;
    assign OVERFLOW   = overflow_q;
    assign READ_ERROR = read_error_q;

endmodule

// File: tb/tb_monopix2_ro_emulator.sv
// Bench for monopix2_ro_emulator: directed scenarios plus random traffic,
// all compared against a queue-based readout model.
module tb_monopix2_ro_emulator;

    localparam int W  = 27;
    localparam int D  = 16;
    localparam int CW = 5;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          HIT_WRITE = 1'b0;
    logic [W-1:0]  HIT_DATA = '0;
    logic          FREEZE = 1'b0;
    logic          READ = 1'b0;
    logic          HIT_FULL, TOKEN, DATA_OUT, OVERFLOW, READ_ERROR;
    logic [CW-1:0] HIT_COUNT;

    int n_assert = 0;
    int n_fail   = 0;

    monopix2_ro_emulator #(.WORD_WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RESET(RESET), .HIT_WRITE(HIT_WRITE), .HIT_DATA(HIT_DATA),
        .HIT_FULL(HIT_FULL), .FREEZE(FREEZE), .READ(READ), .TOKEN(TOKEN),
        .DATA_OUT(DATA_OUT), .HIT_COUNT(HIT_COUNT), .OVERFLOW(OVERFLOW),
        .READ_ERROR(READ_ERROR)
    );

    always #5 CLK = ~CLK;

    // Reference model: hit queue, frame counter, and the cycle of the last
    // accepted READ edge (pop one cycle later, bits 2..28 cycles later).
    logic [W-1:0] mq[$];
    logic [W-1:0] m_word = '0;
    int  m_frame = 0, m_cyc = 0, m_last = -1000, m_cnt = 0;
    bit  m_frz_prev = 0, m_rd_prev = 0, m_pop, m_full, m_rise, m_accept;
    bit  e_token = 0, e_dout = 0, e_ovf = 0, e_rerr = 0;
    int  e_count = 0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mq.delete();
            m_frame = 0; m_last = -1000; m_frz_prev = 0; m_rd_prev = 0;
            e_token = 0; e_dout = 0; e_ovf = 0; e_rerr = 0; e_count = 0;
        end else begin
            m_cyc++;
            m_cnt    = mq.size();
            m_full   = (m_cnt == D);
            m_pop    = (m_cyc == m_last + 1);
            m_rise   = READ && !m_rd_prev;
            m_accept = m_rise && (m_cyc >= m_last + 29) && FREEZE && (m_frame != 0);
            if (m_rise && !m_accept) e_rerr = 1;
            if (m_pop) m_word = mq.pop_front();
            if (HIT_WRITE) begin
                if (!m_full || m_pop) mq.push_back(HIT_DATA);
                else e_ovf = 1;
            end
            if (!FREEZE) m_frame = 0;
            else if (!m_frz_prev) m_frame = m_cnt;
            else if (m_pop) m_frame--;
            if (m_accept) m_last = m_cyc;
            if (m_cyc >= m_last + 2 && m_cyc <= m_last + 28)
                e_dout = m_word[W - 1 - (m_cyc - m_last - 2)];
            else
                e_dout = 0;
            e_token = FREEZE ? (m_frame != 0) : (mq.size() != 0);
            e_count = mq.size();
            m_frz_prev = FREEZE;
            m_rd_prev  = READ;
        end
    end

    logic [9:0] obs_vec, exp_vec;
    assign obs_vec = {TOKEN, DATA_OUT, HIT_FULL, OVERFLOW, READ_ERROR, HIT_COUNT};
    assign exp_vec = {e_token, e_dout, e_count == D, e_ovf, e_rerr, CW'(e_count)};

    task automatic do_reset();
        RESET = 1'b1; HIT_WRITE = 1'b0; FREEZE = 1'b0; READ = 1'b0; HIT_DATA = '0;
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        HIT_WRITE = 1'b1; HIT_DATA = w;
        @(negedge CLK);
        HIT_WRITE = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        n_assert++; if (DATA_OUT !== 1'b0)  begin n_fail++; $display("FAIL reset_dout: got %b want 0", DATA_OUT); end
        n_assert++; if (TOKEN !== 1'b0)     begin n_fail++; $display("FAIL reset_token: got %b want 0", TOKEN); end
        n_assert++; if (HIT_FULL !== 1'b0)  begin n_fail++; $display("FAIL reset_full: got %b want 0", HIT_FULL); end
        n_assert++; if (HIT_COUNT !== '0)   begin n_fail++; $display("FAIL reset_count: got %0d want 0", HIT_COUNT); end
        n_assert++; if (OVERFLOW !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
        n_assert++; if (READ_ERROR !== 1'b0) begin n_fail++; $display("FAIL reset_rerr: got %b want 0", READ_ERROR); end
        RESET = 1'b0;
    endtask

    task automatic test_single_word();
        logic [W-1:0] w, got;
        w = 27'h5A5A5A5; got = '0;
        do_reset();
        push_word(w);
        n_assert++; if (HIT_COUNT !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", HIT_COUNT); end
        FREEZE = 1'b1;
        @(negedge CLK); @(negedge CLK);
        n_assert++; if (TOKEN !== 1'b1) begin n_fail++; $display("FAIL single_token_pre: got %b want 1", TOKEN); end
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            logic eb;
            @(negedge CLK);
            eb = 1'b0;
            if (j >= 2 && j <= 28) begin
                eb  = w[28 - j];
                got = {got[W-2:0], DATA_OUT};
            end
            n_assert++; if (DATA_OUT !== eb) begin n_fail++; $display("FAIL single_bit j=%0d: got %b want %b", j, DATA_OUT, eb); end
            n_assert++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL single_model j=%0d: got %b want %b", j, obs_vec, exp_vec); end
        end
        n_assert++; if (got !== w)         begin n_fail++; $display("FAIL single_word: got %h want %h", got, w); end
        n_assert++; if (TOKEN !== 1'b0)    begin n_fail++; $display("FAIL single_token_post: got %b want 0", TOKEN); end
        n_assert++; if (READ_ERROR !== 1'b0) begin n_fail++; $display("FAIL single_rerr: got %b want 0", READ_ERROR); end
        FREEZE = 1'b0;
    endtask

    task automatic test_frame();
        logic [W-1:0] words [5];
        logic [W-1:0] got;
        do_reset();
        foreach (words[i]) words[i] = W'($urandom);
        for (int i = 0; i < 3; i++) push_word(words[i]);
        FREEZE = 1'b1;
        for (int i = 3; i < 5; i++) push_word(words[i]);
        @(negedge CLK);
        for (int r = 0; r < 3; r++) begin
            READ = 1'b1;
            @(negedge CLK);
            READ = 1'b0;
            got = '0;
            for (int j = 1; j <= 29; j++) begin
                @(negedge CLK);
                if (j >= 2 && j <= 28) got = {got[W-2:0], DATA_OUT};
                n_assert++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL frame_model r=%0d j=%0d: got %b want %b", r, j, obs_vec, exp_vec); end
            end
            n_assert++; if (got !== words[r]) begin n_fail++; $display("FAIL frame_word r=%0d: got %h want %h", r, got, words[r]); end
        end
        n_assert++; if (TOKEN !== 1'b0)     begin n_fail++; $display("FAIL frame_token_frozen: got %b want 0", TOKEN); end
        n_assert++; if (HIT_COUNT !== 5'd2) begin n_fail++; $display("FAIL frame_count: got %0d want 2", HIT_COUNT); end
        FREEZE = 1'b0;
        @(negedge CLK);
        n_assert++; if (TOKEN !== 1'b1)     begin n_fail++; $display("FAIL frame_token_thaw: got %b want 1", TOKEN); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] words [17];
        logic [W-1:0] got;
        do_reset();
        foreach (words[i]) words[i] = W'($urandom);
        for (int i = 0; i < 17; i++) begin
            push_word(words[i]);
            if (i == 14) begin
                n_assert++; if (HIT_FULL !== 1'b0) begin n_fail++; $display("FAIL ovf_full_15: got %b want 0", HIT_FULL); end
            end
            if (i == 15) begin
                n_assert++; if (HIT_FULL !== 1'b1) begin n_fail++; $display("FAIL ovf_full_16: got %b want 1", HIT_FULL); end
                n_assert++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", OVERFLOW); end
            end
        end
        n_assert++; if (OVERFLOW !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag: got %b want 1", OVERFLOW); end
        n_assert++; if (HIT_COUNT !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", HIT_COUNT); end
        FREEZE = 1'b1;
        @(negedge CLK); @(negedge CLK);
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0; HIT_WRITE = 1'b1; HIT_DATA = W'($urandom);
        @(negedge CLK);
        HIT_WRITE = 1'b0;
        n_assert++; if (HIT_COUNT !== 5'd16) begin n_fail++; $display("FAIL ovf_pushpop_count: got %0d want 16", HIT_COUNT); end
        n_assert++; if (HIT_FULL !== 1'b1)   begin n_fail++; $display("FAIL ovf_pushpop_full: got %b want 1", HIT_FULL); end
        got = '0;
        for (int j = 2; j <= 29; j++) begin
            @(negedge CLK);
            if (j <= 28) got = {got[W-2:0], DATA_OUT};
            n_assert++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL ovf_model j=%0d: got %b want %b", j, obs_vec, exp_vec); end
        end
        n_assert++; if (got !== words[0]) begin n_fail++; $display("FAIL ovf_word: got %h want %h", got, words[0]); end
        FREEZE = 1'b0;
    endtask

    task automatic test_read_error();
        logic [W-1:0] w, got;
        do_reset();
        w = W'($urandom);
        push_word(w);
        FREEZE = 1'b1;
        @(negedge CLK); @(negedge CLK);
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0;
        got = '0;
        for (int j = 1; j <= 29; j++) begin
            @(negedge CLK);
            if (j >= 2 && j <= 28) got = {got[W-2:0], DATA_OUT};
            n_assert++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rerr_model j=%0d: got %b want %b", j, obs_vec, exp_vec); end
            if (j == 4) READ = 1'b1;
            if (j == 5) READ = 1'b0;
        end
        n_assert++; if (got !== w)            begin n_fail++; $display("FAIL rerr_word: got %h want %h", got, w); end
        n_assert++; if (READ_ERROR !== 1'b1)  begin n_fail++; $display("FAIL rerr_busy: got %b want 1", READ_ERROR); end
        FREEZE = 1'b0;

        do_reset();
        push_word(w);
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge CLK);
            n_assert++; if (DATA_OUT !== 1'b0) begin n_fail++; $display("FAIL rerr_nofrz_dout j=%0d: got %b want 0", j, DATA_OUT); end
        end
        n_assert++; if (READ_ERROR !== 1'b1) begin n_fail++; $display("FAIL rerr_nofrz: got %b want 1", READ_ERROR); end
        n_assert++; if (HIT_COUNT !== 5'd1)  begin n_fail++; $display("FAIL rerr_nofrz_count: got %0d want 1", HIT_COUNT); end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] w;
        do_reset();
        w = W'($urandom);
        push_word(w);
        FREEZE = 1'b1;
        @(negedge CLK); @(negedge CLK);
        READ = 1'b1;
        @(negedge CLK);
        READ = 1'b0;
        repeat (18) @(negedge CLK);
        n_assert++; if (DATA_OUT !== w[10]) begin n_fail++; $display("FAIL rst_bit10: got %b want %b", DATA_OUT, w[10]); end
        #2 RESET = 1'b1;
        #1;
        n_assert++; if (DATA_OUT !== 1'b0) begin n_fail++; $display("FAIL rst_dout: got %b want 0", DATA_OUT); end
        n_assert++; if (HIT_COUNT !== '0)  begin n_fail++; $display("FAIL rst_count: got %0d want 0", HIT_COUNT); end
        n_assert++; if (TOKEN !== 1'b0)    begin n_fail++; $display("FAIL rst_token: got %b want 0", TOKEN); end
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            n_assert++; if (DATA_OUT !== 1'b0) begin n_fail++; $display("FAIL rst_residual k=%0d: got %b want 0", k, DATA_OUT); end
            n_assert++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL rst_model k=%0d: got %b want %b", k, obs_vec, exp_vec); end
            READ = (k == 5 || k == 20);
        end
        n_assert++; if (READ_ERROR !== 1'b1) begin n_fail++; $display("FAIL rst_rerr: got %b want 1", READ_ERROR); end
        FREEZE = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            n_assert++; if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random_model c=%0d: got %b want %b", c, obs_vec, exp_vec); end
            HIT_WRITE = ($urandom_range(0, 99) < 45);
            HIT_DATA  = W'($urandom);
            if ($urandom_range(0, 99) < 4) FREEZE = ~FREEZE;
            READ = ($urandom_range(0, 99) < 15);
        end
        HIT_WRITE = 1'b0; READ = 1'b0; FREEZE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_frame();
        test_overflow();
        test_read_error();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
